// File: rtl/ppu_pixel_fifo.sv
// Draw-stage pixel FIFO and mixer: the BG fetcher appends tile rows, the sprite fetcher overlays
// rows onto the head entries, and the mixer emits one palette-shaded pixel per cycle to the LCD.
module ppu_pixel_fifo #(
  parameter int DEPTH   = 16,
  parameter int ROW_PX  = 8,
  parameter int LINE_PX = 160
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         line_start,
  input  logic [2:0]                   fine_scroll,
  input  logic                         bg_push_valid,
  input  logic [ROW_PX-1:0]            bg_row_lo,
  input  logic [ROW_PX-1:0]            bg_row_hi,
  output logic                         bg_push_ready,
  input  logic                         sp_merge_valid,
  input  logic [ROW_PX-1:0]            sp_row_lo,
  input  logic [ROW_PX-1:0]            sp_row_hi,
  input  logic [7:0]                   sp_attr,
  output logic                         sp_merge_ready,
  input  logic                         px_stall,
  input  logic                         bg_en,
  input  logic                         sp_en,
  input  logic [7:0]                   bgp,
  input  logic [7:0]                   obp0,
  input  logic [7:0]                   obp1,
  output logic [1:0]                   px_out,
  output logic                         px_valid,
  output logic                         line_done,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PIX_W = $clog2(LINE_PX + 1);
  localparam int RW    = (ROW_PX > 1) ? $clog2(ROW_PX) : 1;

  typedef enum logic [1:0] {IDLE, DISCARD, RUN, DONE} state_t;

  typedef struct packed {
    logic [1:0] bgc;
    logic [1:0] spc;
    logic       sp_pal;
    logic       sp_prio;
  } entry_t;

  state_t             state_q, state_d;
  entry_t             fifo_q [DEPTH];
  entry_t             fifo_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [LVL_W-1:0]   count_q, count_d;
  logic [2:0]         discard_q, discard_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [1:0]         px_out_q, px_out_d;
  logic               px_valid_q, px_valid_d;
  logic               line_done_q, line_done_d;

  logic               active;
  logic               push_acc;
  logic               merge_acc;
  logic               pop;
  entry_t             head_e;
  logic [1:0]         bg_c;
  logic               sp_show;
  logic [1:0]         mix_c;
  logic [7:0]         mix_pal;
  logic [1:0]         shade;
  logic [PTR_W-1:0]   idx;
  logic [RW-1:0]      bit_sel;
  logic [1:0]         new_c;
  logic               unused_attr;

  assign unused_attr = ^{sp_attr[6], sp_attr[3:0]};

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(off);
    if (sum >= (PTR_W+1)'(DEPTH)) sum = sum - (PTR_W+1)'(DEPTH);
    return sum[PTR_W-1:0];
  endfunction

  assign active         = (state_q == DISCARD) || (state_q == RUN);
  assign bg_push_ready  = active && (count_q <= LVL_W'(DEPTH - ROW_PX));
  assign sp_merge_ready = active && (count_q >= LVL_W'(ROW_PX));
  assign push_acc       = bg_push_valid && bg_push_ready && !line_start;
  assign merge_acc      = sp_merge_valid && sp_merge_ready && !line_start;
  // A merge rewrites the head entries, so output holds for that cycle.
  assign pop            = active && (count_q != '0) && !px_stall && !merge_acc && !line_start;

  always_comb begin
    head_e  = fifo_q[head_q];
    bg_c    = bg_en ? head_e.bgc : 2'd0;
    sp_show = sp_en && (head_e.spc != 2'd0) && !(head_e.sp_prio && (bg_c != 2'd0));
    mix_c   = sp_show ? head_e.spc : bg_c;
    mix_pal = sp_show ? (head_e.sp_pal ? obp1 : obp0) : bgp;
    shade   = mix_pal[{mix_c, 1'b0} +: 2];
  end

  always_comb begin
    state_d     = state_q;
    fifo_d      = fifo_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    discard_d   = discard_q;
    pix_cnt_d   = pix_cnt_q;
    px_out_d    = 2'd0;
    px_valid_d  = 1'b0;
    line_done_d = (state_q == DONE) && px_valid_q;
    idx         = '0;
    bit_sel     = '0;
    new_c       = 2'd0;

    if (line_start) begin
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      pix_cnt_d = '0;
      discard_d = fine_scroll;
      state_d   = (fine_scroll != 3'd0) ? DISCARD : RUN;
    end else begin
      // Earlier sprite keeps its pixels: only empty, non-transparent slots are taken.
      if (merge_acc) begin
        for (int i = 0; i < ROW_PX; i++) begin
          idx     = wrap_idx(head_q, i);
          bit_sel = sp_attr[5] ? RW'(i) : RW'(ROW_PX - 1 - i);
          new_c   = {sp_row_hi[bit_sel], sp_row_lo[bit_sel]};
          if ((fifo_q[idx].spc == 2'd0) && (new_c != 2'd0)) begin
            fifo_d[idx].spc     = new_c;
            fifo_d[idx].sp_pal  = sp_attr[4];
            fifo_d[idx].sp_prio = sp_attr[7];
          end
        end
      end

      if (push_acc) begin
        for (int i = 0; i < ROW_PX; i++) begin
          idx         = wrap_idx(tail_q, i);
          fifo_d[idx] = '{bgc: {bg_row_hi[ROW_PX-1-i], bg_row_lo[ROW_PX-1-i]},
                          spc: 2'd0, sp_pal: 1'b0, sp_prio: 1'b0};
        end
        tail_d = wrap_idx(tail_q, ROW_PX);
      end

      if (pop) begin
        head_d = wrap_idx(head_q, 1);
        if (state_q == DISCARD) begin
          discard_d = discard_q - 3'd1;
          if (discard_q == 3'd1) state_d = RUN;
        end else begin
          px_valid_d = 1'b1;
          px_out_d   = shade;
          pix_cnt_d  = pix_cnt_q + PIX_W'(1);
          if (pix_cnt_q == PIX_W'(LINE_PX - 1)) state_d = DONE;
        end
      end

      count_d = count_q + (push_acc ? LVL_W'(ROW_PX) : LVL_W'(0)) - (pop ? LVL_W'(1) : LVL_W'(0));

      // Whatever is left once the line is complete is dropped.
      if (state_d == DONE) begin
        count_d = '0;
        head_d  = '0;
        tail_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fifo_q      <= '{default: '0};
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      discard_q   <= '0;
      pix_cnt_q   <= '0;
      px_out_q    <= '0;
      px_valid_q  <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_q      <= fifo_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      discard_q   <= discard_d;
      pix_cnt_q   <= pix_cnt_d;
      px_out_q    <= px_out_d;
      px_valid_q  <= px_valid_d;
      line_done_q <= line_done_d;
    end
  end

  assign px_out    = px_out_q;
  assign px_valid  = px_valid_q;
  assign line_done = line_done_q;
  assign level     = count_q;

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Bench for ppu_pixel_fifo: directed scanline scenarios plus random traffic, compared against a
// queue-based model of the pixel FIFO built from the scanline rules.
module tb_ppu_pixel_fifo;

  localparam int DEPTH   = 16;
  localparam int ROW_PX  = 8;
  localparam int LINE_PX = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       lineStart;
  logic [2:0] fineScroll;
  logic       bgPushValid;
  logic [7:0] bgRowLo, bgRowHi;
  logic       bgPushReady;
  logic       spMergeValid;
  logic [7:0] spRowLo, spRowHi, spAttr;
  logic       spMergeReady;
  logic       pxStall;
  logic       bgEn, spEn;
  logic [7:0] bgp, obp0, obp1;
  logic [1:0] pxOut;
  logic       pxValid;
  logic       lineDone;
  logic [4:0] level;

  always #5 clk = ~clk;

  ppu_pixel_fifo #(.DEPTH(DEPTH), .ROW_PX(ROW_PX), .LINE_PX(LINE_PX)) dut (
    .clk(clk), .rst(rst), .line_start(lineStart), .fine_scroll(fineScroll),
    .bg_push_valid(bgPushValid), .bg_row_lo(bgRowLo), .bg_row_hi(bgRowHi),
    .bg_push_ready(bgPushReady),
    .sp_merge_valid(spMergeValid), .sp_row_lo(spRowLo), .sp_row_hi(spRowHi),
    .sp_attr(spAttr), .sp_merge_ready(spMergeReady),
    .px_stall(pxStall), .bg_en(bgEn), .sp_en(spEn),
    .bgp(bgp), .obp0(obp0), .obp1(obp1),
    .px_out(pxOut), .px_valid(pxValid), .line_done(lineDone), .level(level)
  );

  typedef struct {
    int bgc;
    int spc;
    int pal;
    int prio;
  } pix_t;

  pix_t mq[$];
  int   discardLeft, emitted;
  bit   started, lastFlag;
  int   expValid, expPx, expDone;
  int   nVectors = 0, nMiscompares = 0;
  int   seenValid, seenDone, firstPx, lastPx;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nVectors++;
    if (observed != expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic bit modelActive();
    return started && (emitted < LINE_PX);
  endfunction

  function automatic bit modelBgReady();
    return modelActive() && (mq.size() <= DEPTH - ROW_PX);
  endfunction

  function automatic bit modelSpReady();
    return modelActive() && (mq.size() >= ROW_PX);
  endfunction

  function automatic int shadeOf(input pix_t e);
    int b, c;
    bit show;
    logic [7:0] pal;
    b    = bgEn ? e.bgc : 0;
    show = spEn && (e.spc != 0) && !((e.prio != 0) && (b != 0));
    c    = show ? e.spc : b;
    pal  = show ? ((e.pal != 0) ? obp1 : obp0) : bgp;
    return int'((pal >> (2 * c)) & 8'h3);
  endfunction

  task automatic modelReset();
    mq.delete();
    discardLeft = 0;
    emitted     = 0;
    started     = 0;
    lastFlag    = 0;
    expValid    = 0;
    expPx       = 0;
    expDone     = 0;
  endtask

  task automatic modelStep(input bit ls, input logic [2:0] fs, input bit bv,
                           input logic [7:0] blo, input logic [7:0] bhi, input bit sv,
                           input logic [7:0] slo, input logic [7:0] shi,
                           input logic [7:0] sattr, input bit stall);
    bit   push, merge, pop;
    pix_t e;
    int   b, c;
    expDone  = lastFlag ? 1 : 0;
    lastFlag = 0;
    expValid = 0;
    expPx    = 0;
    if (ls) begin
      mq.delete();
      discardLeft = int'(fs);
      emitted     = 0;
      started     = 1;
    end else begin
      push  = bv && modelBgReady();
      merge = sv && modelSpReady();
      pop   = modelActive() && (mq.size() > 0) && !stall && !merge;
      if (merge) begin
        for (int i = 0; i < ROW_PX; i++) begin
          b = sattr[5] ? i : ROW_PX - 1 - i;
          c = 2 * int'(shi[b]) + int'(slo[b]);
          e = mq[i];
          if (e.spc == 0 && c != 0) begin
            e.spc  = c;
            e.pal  = int'(sattr[4]);
            e.prio = int'(sattr[7]);
            mq[i]  = e;
          end
        end
      end
      if (pop) begin
        e = mq.pop_front();
        if (discardLeft > 0) discardLeft--;
        else begin
          emitted++;
          expValid = 1;
          expPx    = shadeOf(e);
          if (emitted == LINE_PX) lastFlag = 1;
        end
      end
      if (push) begin
        for (int i = 0; i < ROW_PX; i++) begin
          e.bgc  = 2 * int'(bhi[ROW_PX-1-i]) + int'(blo[ROW_PX-1-i]);
          e.spc  = 0;
          e.pal  = 0;
          e.prio = 0;
          mq.push_back(e);
        end
      end
      if (emitted == LINE_PX) mq.delete();
    end
  endtask

  // One clock of stimulus: readies are checked before driving, registered outputs after the edge.
  task automatic applyStimulus(input bit ls, input logic [2:0] fs, input bit bv,
                               input logic [7:0] blo, input logic [7:0] bhi, input bit sv,
                               input logic [7:0] slo, input logic [7:0] shi,
                               input logic [7:0] sattr, input bit stall);
    checkOutput("bg_push_ready", int'(bgPushReady), int'(modelBgReady()));
    checkOutput("sp_merge_ready", int'(spMergeReady), int'(modelSpReady()));
    lineStart    = ls;
    fineScroll   = fs;
    bgPushValid  = bv;
    bgRowLo      = blo;
    bgRowHi      = bhi;
    spMergeValid = sv;
    spRowLo      = slo;
    spRowHi      = shi;
    spAttr       = sattr;
    pxStall      = stall;
    modelStep(ls, fs, bv, blo, bhi, sv, slo, shi, sattr, stall);
    @(posedge clk);
    #1;
    checkOutput("px_valid", int'(pxValid), expValid);
    if (expValid != 0) checkOutput("px_out", int'(pxOut), expPx);
    checkOutput("line_done", int'(lineDone), expDone);
    checkOutput("level", int'(level), mq.size());
    if (pxValid) begin
      if (seenValid == 0) firstPx = int'(pxOut);
      lastPx = int'(pxOut);
      seenValid++;
    end
    if (lineDone) seenDone++;
  endtask

  task automatic idleCycles(input int n, input bit stall);
    for (int i = 0; i < n; i++) applyStimulus(0, 3'd0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, stall);
  endtask

  task automatic startLine(input logic [2:0] fs, input bit stall);
    seenValid = 0;
    seenDone  = 0;
    firstPx   = -1;
    lastPx    = -1;
    applyStimulus(1, fs, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, stall);
  endtask

  task automatic randomCycles(input int n, input int lsPerMille);
    bit ls, bv, sv, st;
    for (int i = 0; i < n; i++) begin
      ls = ($urandom_range(999) < lsPerMille);
      bv = ($urandom_range(99) < 50);
      sv = ($urandom_range(99) < 15);
      st = ($urandom_range(99) < 30);
      applyStimulus(ls, 3'($urandom_range(7)), bv, 8'($urandom), 8'($urandom), sv,
                    8'($urandom), 8'($urandom), 8'($urandom), st);
    end
  endtask

  initial begin
    rst = 1'b1;
    lineStart = 0; fineScroll = 0; bgPushValid = 0; bgRowLo = 0; bgRowHi = 0;
    spMergeValid = 0; spRowLo = 0; spRowHi = 0; spAttr = 0; pxStall = 0;
    bgEn = 1; spEn = 1; bgp = 8'hE4; obp0 = 8'hE4; obp1 = 8'h80;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_level", int'(level), 0);
    checkOutput("rst_px_valid", int'(pxValid), 0);
    checkOutput("rst_px_out", int'(pxOut), 0);
    checkOutput("rst_line_done", int'(lineDone), 0);
    checkOutput("rst_bg_ready", int'(bgPushReady), 0);
    checkOutput("rst_sp_ready", int'(spMergeReady), 0);
    rst = 1'b0;
    modelReset();

    $display("[TB] plain BG row, no scroll");
    startLine(3'd0, 0);
    applyStimulus(0, 3'd0, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    idleCycles(12, 0);
    checkOutput("s1_count", seenValid, 8);
    checkOutput("s1_first", firstPx, 1);
    checkOutput("s1_level", int'(level), 0);

    $display("[TB] fine scroll discard");
    startLine(3'd3, 0);
    applyStimulus(0, 3'd0, 1, 8'hF0, 8'h0F, 0, 8'h00, 8'h00, 8'h00, 0);
    idleCycles(12, 0);
    checkOutput("s2_count", seenValid, 5);
    checkOutput("s2_first", firstPx, 1);
    checkOutput("s2_last", lastPx, 2);

    $display("[TB] sprite over transparent BG");
    bgp = 8'hE5;
    startLine(3'd0, 1);
    applyStimulus(0, 3'd0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus(0, 3'd0, 0, 8'h00, 8'h00, 1, 8'h80, 8'h80, 8'h00, 1);
    idleCycles(10, 0);
    checkOutput("s3_first", firstPx, 3);
    checkOutput("s3_last", lastPx, 1);

    $display("[TB] BG priority and X-flip");
    bgp = 8'hE4;
    startLine(3'd0, 1);
    applyStimulus(0, 3'd0, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus(0, 3'd0, 0, 8'h00, 8'h00, 1, 8'h80, 8'h80, 8'h80, 1);
    idleCycles(10, 0);
    checkOutput("s4_prio_bg", firstPx, 1);
    startLine(3'd0, 1);
    applyStimulus(0, 3'd0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus(0, 3'd0, 0, 8'h00, 8'h00, 1, 8'h80, 8'h80, 8'h80, 1);
    idleCycles(10, 0);
    checkOutput("s4_prio_sp", firstPx, 3);
    startLine(3'd0, 1);
    applyStimulus(0, 3'd0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus(0, 3'd0, 0, 8'h00, 8'h00, 1, 8'h80, 8'h00, 8'h20, 1);
    idleCycles(10, 0);
    checkOutput("s4_xflip_first", firstPx, 0);
    checkOutput("s4_xflip_last", lastPx, 1);

    $display("[TB] overlapping sprites and full FIFO");
    startLine(3'd0, 1);
    applyStimulus(0, 3'd0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus(0, 3'd0, 0, 8'h00, 8'h00, 1, 8'hF0, 8'h00, 8'h00, 1);
    applyStimulus(0, 3'd0, 0, 8'h00, 8'h00, 1, 8'hFF, 8'hFF, 8'h10, 1);
    idleCycles(10, 0);
    checkOutput("s5_first", firstPx, 1);
    checkOutput("s5_last", lastPx, 2);
    startLine(3'd0, 1);
    applyStimulus(0, 3'd0, 1, 8'h55, 8'h33, 0, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus(0, 3'd0, 1, 8'hAA, 8'h0F, 0, 8'h00, 8'h00, 8'h00, 1);
    idleCycles(7, 0);
    checkOutput("s5_level", int'(level), DEPTH - ROW_PX + 1);
    checkOutput("s5_bg_ready", int'(bgPushReady), 0);
    idleCycles(12, 0);

    $display("[TB] full scanline with random stalls");
    startLine(3'($urandom_range(7)), 0);
    randomCycles(1000, 0);
    checkOutput("s6_pixels", seenValid, LINE_PX);
    checkOutput("s6_done_pulses", seenDone, 1);
    startLine(3'd2, 0);
    randomCycles(50, 0);
    startLine(3'($urandom_range(7)), 0);
    randomCycles(1000, 0);
    checkOutput("s6_restart_pixels", seenValid, LINE_PX);
    checkOutput("s6_restart_done", seenDone, 1);

    $display("[TB] random soak");
    for (int blk = 0; blk < 60; blk++) begin
      bgEn = 1'($urandom);
      spEn = 1'($urandom);
      bgp  = 8'($urandom);
      obp0 = 8'($urandom);
      obp1 = 8'($urandom);
      randomCycles(50, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
